if_id_stage: RTL and testbench



---
 rtl/if_id_stage.sv | 129 ++++++++++++
 tb/tb_if_id_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Purpose  : Instruction fetch stage with IF/ID pipeline register. Owns the
//            program counter, reads 16-bit words from an asynchronous-read
//            instruction memory and assembles one complete instruction
//            (opcode word plus optional immediate word) per valid ID slot.
// Ports    : clk_in, rst_n_in         - clock / async active-low reset
//            HDU_stall_in             - freeze PC, FSM and IF/ID contents
//            branch_taken_EX_in       - flush wrong-path work and redirect
//            branch_target_EX_in      - redirect address
//            inst_mem_data_in         - memory word at pc_out
//            pc_out                   - current fetch address (registered)
//            inst_ID_out / imm_ID_out - opcode word / immediate word to decode
//            pc_next_ID_out           - address after the instruction's last word
//            valid_ID_out             - ID slot holds a real instruction
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                HDU_stall_in,
  input  logic                branch_taken_EX_in,
  input  logic [PC_WIDTH-1:0] branch_target_EX_in,
  input  logic [15:0]         inst_mem_data_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [15:0]         inst_ID_out,
  output logic [15:0]         imm_ID_out,
  output logic [PC_WIDTH-1:0] pc_next_ID_out,
  output logic                valid_ID_out
);

  typedef enum logic [0:0] {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } state_t;

  state_t              state_q,   state_d;
  logic [PC_WIDTH-1:0] pc_q,      pc_d;
  logic [15:0]         pending_q, pending_d;
  logic [15:0]         inst_q,    inst_d;
  logic [15:0]         imm_q,     imm_d;
  logic [PC_WIDTH-1:0] pcn_q,     pcn_d;
  logic                valid_q,   valid_d;

  // Modulo-2^PC_WIDTH increment; the carry out is simply dropped.
  logic [PC_WIDTH-1:0] pc_plus1;
  assign pc_plus1 = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    inst_d    = inst_q;
    imm_d     = imm_q;
    pcn_d     = pcn_q;
    valid_d   = valid_q;

    if (branch_taken_EX_in) begin
      // Flush outranks stall: drop any half-fetched instruction.
      pc_d      = branch_target_EX_in;
      state_d   = FETCH_OP;
      pending_d = '0;
      inst_d    = '0;
      imm_d     = '0;
      pcn_d     = '0;
      valid_d   = 1'b0;
    end else if (!HDU_stall_in) begin
      pc_d = pc_plus1;
      case (state_q)
        FETCH_OP: begin
          if (inst_mem_data_in[0]) begin
            // Opcode carries an immediate: park it and emit a bubble.
            pending_d = inst_mem_data_in;
            state_d   = FETCH_IMM;
            inst_d    = '0;
            imm_d     = '0;
            pcn_d     = '0;
            valid_d   = 1'b0;
          end else begin
            inst_d  = inst_mem_data_in;
            imm_d   = '0;
            pcn_d   = pc_plus1;
            valid_d = 1'b1;
          end
        end
        FETCH_IMM: begin
          inst_d  = pending_q;
          imm_d   = inst_mem_data_in;
          pcn_d   = pc_plus1;
          valid_d = 1'b1;
          state_d = FETCH_OP;
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      pending_q <= '0;
      inst_q    <= '0;
      imm_q     <= '0;
      pcn_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      inst_q    <= inst_d;
      imm_q     <= imm_d;
      pcn_q     <= pcn_d;
      valid_q   <= valid_d;
    end
  end

  assign pc_out         = pc_q;
  assign inst_ID_out    = inst_q;
  assign imm_ID_out     = imm_q;
  assign pc_next_ID_out = pcn_q;
  assign valid_ID_out   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Purpose  : Self-checking bench for if_id_stage. A behavioural model collects
//            fetched words per instruction and predicts the ID slot each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic [15:0] mem [0:255];
  logic [15:0] mem_data;
  logic [31:0] pc_out;
  logic [15:0] inst, imm;
  logic [31:0] pcn;
  logic        valid;

  // Narrow instance used only for the PC wrap-around case.
  logic        rst4_n = 1'b0;
  logic [3:0]  pc4, pcn4;
  logic [15:0] inst4, imm4;
  logic        valid4;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [15:0] m_words [$];
  logic [15:0] e_inst, e_imm;
  logic [31:0] e_pcn;
  logic        e_valid;

  always #5 clk = ~clk;

  assign mem_data = mem[pc_out[7:0]];

  if_id_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .HDU_stall_in(stall),
    .branch_taken_EX_in(br), .branch_target_EX_in(tgt),
    .inst_mem_data_in(mem_data), .pc_out(pc_out), .inst_ID_out(inst),
    .imm_ID_out(imm), .pc_next_ID_out(pcn), .valid_ID_out(valid)
  );

  if_id_stage #(.PC_WIDTH(4), .RESET_PC(4'hF)) dut4 (
    .clk_in(clk), .rst_n_in(rst4_n), .HDU_stall_in(1'b0),
    .branch_taken_EX_in(1'b0), .branch_target_EX_in(4'h0),
    .inst_mem_data_in(16'h3000), .pc_out(pc4), .inst_ID_out(inst4),
    .imm_ID_out(imm4), .pc_next_ID_out(pcn4), .valid_ID_out(valid4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_words.delete();
    e_inst = '0; e_imm = '0; e_pcn = '0; e_valid = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    64'(pc_out), 64'(m_pc));
    chk({tag, ".inst"},  64'(inst),   64'(e_inst));
    chk({tag, ".imm"},   64'(imm),    64'(e_imm));
    chk({tag, ".pcn"},   64'(pcn),    64'(e_pcn));
    chk({tag, ".valid"}, 64'(valid),  64'(e_valid));
  endtask

  // One clock with the given controls; the model predicts from the
  // instruction format rules and the DUT is compared after the edge.
  task automatic step(input string tag, input logic s, input logic b, input logic [31:0] t);
    logic [15:0] w;
    logic [31:0] nxt;
    stall = s; br = b; tgt = t;
    if (b) begin
      m_pc = t;
      m_words.delete();
      e_inst = '0; e_imm = '0; e_pcn = '0; e_valid = 1'b0;
    end else if (!s) begin
      w   = mem[m_pc[7:0]];
      nxt = m_pc + 32'd1;
      m_pc = nxt;
      m_words.push_back(w);
      if (m_words.size() == 2 || !m_words[0][0]) begin
        e_inst  = m_words[0];
        e_imm   = (m_words.size() == 2) ? m_words[1] : 16'h0;
        e_pcn   = nxt;
        e_valid = 1'b1;
        m_words.delete();
      end else begin
        e_inst = '0; e_imm = '0; e_pcn = '0; e_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    stall = 1'b0; br = 1'b0;
    chk_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_model("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    // Straight-line code plus a 3-cycle stall with 16'h1000 in ID.
    mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'h3000;
    do_reset();
    chk("rst.pc_out", 64'(pc_out), 64'h0);
    step("sl1", 1'b0, 1'b0, '0);
    chk("sl1.inst", 64'(inst), 64'h1000);
    chk("sl1.pcn", 64'(pcn), 64'h1);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 1'b0, '0);
      chk("stall.pc_out", 64'(pc_out), 64'h1);
      chk("stall.inst", 64'(inst), 64'h1000);
    end
    step("sl2", 1'b0, 1'b0, '0);
    chk("sl2.inst", 64'(inst), 64'h2000);
    chk("sl2.pcn", 64'(pcn), 64'h2);
    step("sl3", 1'b0, 1'b0, '0);
    chk("sl3.inst", 64'(inst), 64'h3000);

    // Immediate instruction, then flush+stall while in the immediate fetch.
    mem[0] = 16'h5001; mem[1] = 16'hABCD; mem[2] = 16'h7003;
    mem[8'h40] = 16'h1234; mem[8'h41] = 16'h0009;
    do_reset();
    step("imm1", 1'b0, 1'b0, '0);
    chk("imm1.valid", 64'(valid), 64'h0);
    step("imm2", 1'b0, 1'b0, '0);
    chk("imm2.inst", 64'(inst), 64'h5001);
    chk("imm2.imm", 64'(imm), 64'hABCD);
    chk("imm2.pcn", 64'(pcn), 64'h2);
    step("pre_flush", 1'b0, 1'b0, '0);
    step("flush", 1'b1, 1'b1, 32'h40);
    chk("flush.pc_out", 64'(pc_out), 64'h40);
    chk("flush.valid", 64'(valid), 64'h0);
    step("post_flush", 1'b0, 1'b0, '0);
    chk("post_flush.inst", 64'(inst), 64'h1234);
    chk("post_flush.pcn", 64'(pcn), 64'h41);

    // Async reset in the middle of an immediate fetch.
    step("to_imm", 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.pc_out", 64'(pc_out), 64'h0);
    chk("async.valid", 64'(valid), 64'h0);
    chk("async.inst", 64'(inst), 64'h0);
    chk("async.pcn", 64'(pcn), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // The stray edge above ran under reset's shadow? No: rst_n rose at negedge,
    // so that edge fetched mem[0]; account for it in the model.
    begin
      m_pc = 32'h1;
      m_words.push_back(mem[0]);
    end
    chk_model("after_async");
    step("after_async2", 1'b0, 1'b0, '0);
    chk("after_async2.inst", 64'(inst), 64'h5001);

    // Randomized run against the model.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      logic s, b;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom;
      step("rand", s, b, t);
    end

    // PC wrap on a 4-bit instance.
    @(negedge clk);
    chk("wrap.rst_pc", 64'(pc4), 64'hF);
    rst4_n = 1'b1;
    @(posedge clk); #1;
    chk("wrap.inst", 64'(inst4), 64'h3000);
    chk("wrap.pcn", 64'(pcn4), 64'h0);
    chk("wrap.pc_out", 64'(pc4), 64'h0);
    chk("wrap.valid", 64'(valid4), 64'h1);
    chk("wrap.imm", 64'(imm4), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
